muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle multiply/divide controller attached beside the EXECUTE stage. It accepts MULT/MULTU/DIV/DIVU requests on forwarded operands and sequences an iterative shift-add multiplier or restoring divider over XLEN cycles. While it runs, it stalls the front of the pipeline, then writes the HI/LO result registers read by MFHI/MFLO. Decode raises the request; the hazard logic consumes the stall.

## Interface
- XLEN, 32, operand width; HI/LO are XLEN each; iteration counter is $clog2(XLEN)+1 bits.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- ip_start  in  1  request valid; sampled only in IDLE or DONE.
- ip_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with ip_start.
- ip_A  in  XLEN  forwarded rs operand; sampled with ip_start.
- ip_B  in  XLEN  forwarded rt operand; sampled with ip_start.
- ip_flush  in  1  abort the in-flight operation (branch taken/squash).
- op_stall  out  1  holds PC, IF/ID and ID/EX registers.
- op_done  out  1  one-cycle pulse; HI/LO updated on the same edge.
- op_div_by_zero  out  1  pulses with op_done when a divide had B==0.
- op_illegal  out  1  one-cycle pulse for a rejected request (see Configuration).
- op_HI  out  XLEN  high product or remainder.
- op_LO  out  XLEN  low product or quotient.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE, start=1 → PREP: latch op, signs sA=A[XLEN-1] and sB=B[XLEN-1] (forced 0 for unsigned), magnitudes |A| and |B| (two's-complement negate; 0x8000_0000 stays 0x8000_0000 as unsigned).
- PREP → RUN: clear 2·XLEN accumulator, load counter with XLEN.
- RUN, multiply: if multiplier LSB is 1, add multiplicand into upper half; shift right 1. Decrement the counter; at 1 → FIX.
- RUN, divide: shift remainder:quotient left 1; trial subtract |B|; if non-negative, keep the result and set the quotient LSB.
- FIX, multiply: if sA^sB, negate the 2·XLEN product.
- FIX, divide: quotient negated if sA^sB; remainder negated if sA.
- FIX → DONE: on this edge HI/LO are written and op_done asserts.
- Divide by zero: runs the full latency. Result is forced to LO=all ones, HI=ip_A original value, op_div_by_zero=1.
- DIV 0x8000_0000 / -1 yields LO=0x8000_0000, HI=0 (natural wrap, no flag).
- DONE → PREP if ip_start, else → IDLE.
- op_stall = (IDLE|DONE)&ip_start | PREP | RUN | FIX. It is low in DONE without a new start, so the consuming instruction advances.
- ip_start in PREP/RUN/FIX is ignored. Decode holds it under stall.
- ip_flush in any state → IDLE next edge. It overrides start on the same edge, writes no HI/LO and gives no op_done. op_stall is masked low combinationally the same cycle.

## Timing
- Start sampled at edge N. Cycles: PREP N+1, RUN N+2…N+XLEN+1, FIX N+XLEN+2. op_done is high in cycle N+XLEN+3, i.e. XLEN+3 cycles latency (35 at XLEN=32).
- HI/LO change only on the FIX→DONE edge and are stable otherwise.
- Back-to-back start in DONE: next op_done exactly XLEN+3 cycles later.
- Reset values: state IDLE; op_HI=0, op_LO=0, op_stall=0, op_done=0, op_div_by_zero=0, op_illegal=0. Reset mid-operation discards all progress.

## Configuration
- MULDIV_DIV_EN defined: divider datapath and divide paths are built as above; op_illegal tied 0.
- MULDIV_DIV_EN undefined: only MULT/MULTU accepted. A start with ip_op[1]=1 leaves the FSM in IDLE with op_stall low. op_illegal pulses on the following cycle, and HI/LO are unchanged.

## Test plan
- MULT A=-3 (0xFFFF_FFFD), B=7 → op_done at N+35; HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; stall high cycles N…N+34.
- MULTU A=B=0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV A=-7, B=2 → LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); DIVU A=7, B=0 → LO=0xFFFF_FFFF, HI=7, op_div_by_zero=1 with op_done.
- Flush at N+10 of a MULT → IDLE at N+11, op_stall low from N+10, no op_done, HI/LO keep prior values.
- Start held in DONE with DIVU 100/9 → second op_done 35 cycles later, LO=11, HI=1; async reset pulse mid-RUN → all outputs 0 immediately.
- Build without MULDIV_DIV_EN: DIV start → op_illegal one cycle, op_stall never asserts, HI/LO unchanged; MULT still passes.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer with pipeline stall and HI/LO results
// Optional divider datapath built only when MULDIV_DIV_EN is defined.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ip_start,
    input  logic [1:0]      ip_op,
    input  logic [XLEN-1:0] ip_A,
    input  logic [XLEN-1:0] ip_B,
    input  logic            ip_flush,
    output logic            op_stall,
    output logic            op_done,
    output logic            op_div_by_zero,
    output logic            op_illegal,
    output logic [XLEN-1:0] op_HI,
    output logic [XLEN-1:0] op_LO
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        r_state;
    logic              r_sa, r_sb;
    logic [XLEN-1:0]   r_ma, r_mb;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo;
    logic              r_done;
    logic              w_window, w_accept, w_div, w_sa_in, w_sb_in;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_step, w_prod;
    logic [XLEN-1:0]   w_res_hi, w_res_lo;

    assign w_window = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_sa_in  = ip_A[XLEN-1] & ~ip_op[0];
    assign w_sb_in  = ip_B[XLEN-1] & ~ip_op[0];

`ifdef MULDIV_DIV_EN
    logic              r_div, r_dbz;
    logic [XLEN-1:0]   r_a_orig;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN+1:0]   w_trial;
    logic              w_res_dbz;
    assign w_accept       = w_window & ip_start;
    assign w_div          = r_div;
    assign op_div_by_zero = r_dbz;
    assign op_illegal     = 1'b0;
`else
    logic              r_illegal;
    assign w_accept       = w_window & ip_start & ~ip_op[1];
    assign w_div          = 1'b0;
    assign op_div_by_zero = 1'b0;
    assign op_illegal     = r_illegal;
`endif

    // Flush masks the stall in the same cycle so the squashing branch can redirect fetch.
    assign op_stall = ~ip_flush & (w_accept | (r_state == S_PREP) |
                                   (r_state == S_RUN) | (r_state == S_FIX));
    assign op_done  = r_done;
    assign op_HI    = r_hi;
    assign op_LO    = r_lo;

    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_ma} : '0);
        w_step    = {w_mul_sum, r_acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        // Remainder carries an extra bit so divisors above 2^(XLEN-1) never lose the shifted-out MSB.
        w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
        w_trial  = {1'b0, w_rem_sh} - {2'b00, r_mb};
        if (r_div) begin
            if (!w_trial[XLEN+1])
                w_step = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            else
                w_step = {r_acc[2*XLEN-2:0], 1'b0};
        end
`endif
    end

    always_comb begin
        w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_res_hi = w_prod[2*XLEN-1:XLEN];
        w_res_lo = w_prod[XLEN-1:0];
`ifdef MULDIV_DIV_EN
        w_res_dbz = 1'b0;
        if (r_div) begin
            if (r_mb == '0) begin
                w_res_hi  = r_a_orig;
                w_res_lo  = '1;
                w_res_dbz = 1'b1;
            end else begin
                w_res_lo = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
                w_res_hi = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_div    <= 1'b0;
            r_dbz    <= 1'b0;
            r_a_orig <= '0;
`else
            r_illegal <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_dbz <= 1'b0;
`else
            r_illegal <= 1'b0;
`endif
            if (ip_flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (w_accept) begin
                            r_state <= S_PREP;
                            r_sa    <= w_sa_in;
                            r_sb    <= w_sb_in;
                            r_ma    <= w_sa_in ? -ip_A : ip_A;
                            r_mb    <= w_sb_in ? -ip_B : ip_B;
`ifdef MULDIV_DIV_EN
                            r_div    <= ip_op[1];
                            r_a_orig <= ip_A;
`endif
                        end else begin
                            r_state <= S_IDLE;
`ifndef MULDIV_DIV_EN
                            r_illegal <= ip_start & ip_op[1];
`endif
                        end
                    end
                    S_PREP: begin
                        r_acc   <= {{XLEN{1'b0}}, (w_div ? r_ma : r_mb)};
                        r_cnt   <= CW'(XLEN);
                        r_state <= S_RUN;
                    end
                    S_RUN: begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1))
                            r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_done  <= 1'b1;
`ifdef MULDIV_DIV_EN
                        r_dbz   <= w_res_dbz;
`endif
                        r_state <= S_DONE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
